// File: rtl/mem_access_unit_if.sv
// Bus bundles for mem_access_unit: the MEM-stage request/response side and the
// word-wide data-memory side. The modports are named from the initiator's point of view.
interface mau_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [1:0]        mem_size;
  logic              mem_sign;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              done;
  logic              err;
  logic              busy;

  modport master (
    output req_valid, mem_read, mem_write, mem_size, mem_sign, addr, wdata,
    input  req_ready, rdata, done, err, busy
  );
  modport slave (
    input  req_valid, mem_read, mem_write, mem_size, mem_sign, addr, wdata,
    output req_ready, rdata, done, err, busy
  );
endinterface

interface mau_dmem_if #(
  parameter int ADDR_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [3:0]        dmem_be;
  logic [31:0]       dmem_wdata;
  logic              dmem_ack;
  logic [31:0]       dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );
  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: lane steering, load extension and alignment checks.
// Optional ack-wait timeout is compiled in with the MEM_TIMEOUT_EN macro.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  mau_req_if.slave   req,
  mau_dmem_if.master dmem
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [1:0] SizeByte = 2'b01;
  localparam logic [1:0] SizeHalf = 2'b10;
  localparam logic [1:0] SizeWord = 2'b11;

  // A zero timeout would expire before the bus could ever answer.
  if (TIMEOUT < 1) begin : g_timeout_invalid
  end

  state_e            state_q, state_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              dreq_q, dreq_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       dwdata_q, dwdata_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [1:0]        off_q, off_d;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = cnt_q + 1'b1;
`endif

  logic        accept;
  logic        illegal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_ext;

  assign accept = req.req_valid && (state_q == IDLE) && (req.mem_read || req.mem_write);

  // Request decode: byte enables, replicated store data and legality.
  always_comb begin
    // NOTE: every combinational output gets a value before any branch, so no latch is inferred.
    illegal   = 1'b0;
    be_new    = 4'b0000;
    wdata_new = req.wdata;
    case (req.mem_size)
      SizeByte: begin
        be_new    = 4'b0001 << req.addr[1:0];
        wdata_new = {4{req.wdata[7:0]}};
      end
      SizeHalf: begin
        be_new    = 4'b0011 << req.addr[1:0];
        wdata_new = {2{req.wdata[15:0]}};
        illegal   = req.addr[0];
      end
      SizeWord: begin
        be_new  = 4'b1111;
        illegal = (req.addr[1:0] != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    if (req.mem_read && req.mem_write) illegal = 1'b1;
  end

  // Load path works from the captured size/offset, since request inputs are stale by ack time.
  assign lane_byte = dmem.dmem_rdata[{off_q, 3'b000} +: 8];
  assign lane_half = dmem.dmem_rdata[{off_q[1], 4'b0000} +: 16];

  always_comb begin
    case (size_q)
      SizeByte: load_ext = {{24{sign_q & lane_byte[7]}}, lane_byte};
      SizeHalf: load_ext = {{16{sign_q & lane_half[15]}}, lane_half};
      default:  load_ext = dmem.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    dreq_d   = dreq_q;
    we_d     = we_q;
    daddr_d  = daddr_q;
    be_d     = be_q;
    dwdata_d = dwdata_q;
    size_d   = size_q;
    sign_d   = sign_q;
    off_d    = off_q;
`ifdef MEM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          size_d = req.mem_size;
          sign_d = req.mem_sign;
          off_d  = req.addr[1:0];
          if (illegal) begin
            // Rejected requests skip the bus and report straight away.
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d  = REQ;
            dreq_d   = 1'b1;
            we_d     = req.mem_write;
            daddr_d  = {req.addr[ADDR_W-1:2], 2'b00};
            be_d     = be_new;
            dwdata_d = wdata_new;
`ifdef MEM_TIMEOUT_EN
            cnt_d    = '0;
`endif
          end
        end
      end
      REQ: begin
        if (dmem.dmem_ack) begin
          state_d = RESP;
          done_d  = 1'b1;
          dreq_d  = 1'b0;
          if (!we_q) rdata_d = load_ext;
`ifdef MEM_TIMEOUT_EN
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          state_d = RESP;
          done_d  = 1'b1;
          err_d   = 1'b1;
          dreq_d  = 1'b0;
        end else begin
          cnt_d = cnt_inc;
`endif
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      dreq_q   <= 1'b0;
      we_q     <= 1'b0;
      daddr_q  <= '0;
      be_q     <= '0;
      dwdata_q <= '0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      off_q    <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      dreq_q   <= dreq_d;
      we_q     <= we_d;
      daddr_q  <= daddr_d;
      be_q     <= be_d;
      dwdata_q <= dwdata_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      off_q    <= off_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign req.req_ready   = (state_q == IDLE);
  assign req.busy        = (state_q != IDLE);
  assign req.rdata       = rdata_q;
  assign req.done        = done_q;
  assign req.err         = err_q;
  assign dmem.dmem_req   = dreq_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = daddr_q;
  assign dmem.dmem_be    = be_q;
  assign dmem.dmem_wdata = dwdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// transactions compared against a byte-level behavioural model.
module tb_mem_access_unit;

`ifdef MEM_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic clk;
  logic rst_n;

  mau_req_if  #(.ADDR_W(32)) rq ();
  mau_dmem_if #(.ADDR_W(32)) dm ();

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (rq),
    .dmem (dm)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          n_cmp  = 0;
  int          n_fail = 0;
  logic [31:0] model_rdata;

  typedef struct {
    int          lat;
    int          nreq;
    bit          req_seen;
    bit          stable;
    bit          pulse_ok;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] rdata;
    logic        err;
  } obs_t;

  // ---------------- behavioural model ----------------
  function automatic int m_bytes(logic [1:0] sz);
    case (sz)
      2'b01:   return 1;
      2'b10:   return 2;
      2'b11:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit m_legal(bit rd, bit wr, logic [1:0] sz, logic [31:0] a);
    int n;
    n = m_bytes(sz);
    if (n == 0 || (rd && wr)) return 1'b0;
    return (a % n) == 0;
  endfunction

  function automatic logic [3:0] m_be(logic [1:0] sz, logic [31:0] a);
    logic [3:0] b;
    int o;
    b = 4'b0000;
    o = int'(a % 4);
    for (int i = 0; i < m_bytes(sz); i++) b[o + i] = 1'b1;
    return b;
  endfunction

  function automatic logic [31:0] m_store(logic [1:0] sz, logic [31:0] wd);
    logic [31:0] r;
    int n;
    n = m_bytes(sz);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] sz, bit sg, logic [31:0] a);
    int n;
    int o;
    longint v;
    n = m_bytes(sz);
    o = int'(a % 4);
    v = 0;
    for (int i = 0; i < n; i++) v += longint'(w[8*(o + i) +: 8]) << (8*i);
    if (sg && n < 4 && v >= (longint'(1) << (8*n - 1))) v -= longint'(1) << (8*n);
    return v[31:0];
  endfunction

  // ---------------- transaction driver / memory responder ----------------
  // waits < 0 means the memory never acknowledges.
  task automatic run_txn(input bit rd, input bit wr, input logic [1:0] sz, input bit sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mw,
                         input int waits, output obs_t o);
    o = '{lat: -1, nreq: 0, req_seen: 1'b0, stable: 1'b1, pulse_ok: 1'b1,
          we: 1'b0, addr: '0, be: '0, wd: '0, rdata: '0, err: 1'b0};
    @(negedge clk);
    rq.req_valid = 1'b1; rq.mem_read = rd; rq.mem_write = wr;
    rq.mem_size = sz; rq.mem_sign = sg; rq.addr = a; rq.wdata = wd;
    for (int c = 1; c <= 400 && o.lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) begin
        rq.req_valid = 1'b0; rq.mem_read = 1'($urandom); rq.mem_write = 1'($urandom);
        rq.mem_size = 2'($urandom); rq.mem_sign = 1'($urandom);
        rq.addr = $urandom; rq.wdata = $urandom;
      end
      dm.dmem_ack   = 1'b0;
      dm.dmem_rdata = $urandom;
      if (dm.dmem_req) begin
        if (!o.req_seen) begin
          o.we = dm.dmem_we; o.addr = dm.dmem_addr; o.be = dm.dmem_be; o.wd = dm.dmem_wdata;
        end else if (o.we !== dm.dmem_we || o.addr !== dm.dmem_addr ||
                     o.be !== dm.dmem_be || o.wd !== dm.dmem_wdata) begin
          o.stable = 1'b0;
        end
        o.req_seen = 1'b1;
        o.nreq++;
        if (waits >= 0 && o.nreq == waits + 1) begin
          dm.dmem_ack   = 1'b1;
          dm.dmem_rdata = mw;
        end
      end else begin
        dm.dmem_ack = 1'($urandom);  // stray acks outside REQ must be ignored
      end
      if (rq.done) begin
        o.lat = c; o.rdata = rq.rdata; o.err = rq.err;
      end
    end
    @(negedge clk);
    dm.dmem_ack = 1'b0;
    if (rq.done) o.pulse_ok = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [31:0] flat;
    flat = {rq.done, rq.err, dm.dmem_req, dm.dmem_we, dm.dmem_be, 24'd0};
    n_cmp++;
    if (flat !== 32'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %h expected 00000000", flat);
    end
    n_cmp++;
    if (rq.rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rq.rdata);
    end
    n_cmp++;
    if (dm.dmem_addr !== 32'd0 || dm.dmem_wdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_bus: got addr %h wdata %h expected 0", dm.dmem_addr, dm.dmem_wdata);
    end
    n_cmp++;
    if (rq.req_ready !== 1'b1 || rq.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready: got ready %b busy %b expected 1 0", rq.req_ready, rq.busy);
    end
  endtask

  task automatic test_word_load();
    obs_t o;
    run_txn(1'b1, 1'b0, 2'b11, 1'b1, 32'h104, $urandom, 32'hDEAD_BEEF, 0, o);
    n_cmp++;
    if (o.addr !== 32'h104 || o.be !== 4'b1111 || o.we !== 1'b0) begin
      n_fail++; $display("FAIL lw_bus: got addr %h be %b we %b expected 104 1111 0", o.addr, o.be, o.we);
    end
    n_cmp++;
    if (o.lat !== 2) begin
      n_fail++; $display("FAIL lw_latency: got %0d expected 2", o.lat);
    end
    n_cmp++;
    if (o.rdata !== 32'hDEAD_BEEF || o.err !== 1'b0) begin
      n_fail++; $display("FAIL lw_result: got rdata %h err %b expected deadbeef 0", o.rdata, o.err);
    end
    n_cmp++;
    if (!o.pulse_ok) begin
      n_fail++; $display("FAIL lw_done_pulse: got done high 2 cycles expected 1");
    end
    model_rdata = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_loads();
    obs_t o;
    run_txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h203, $urandom, 32'h80FF_FFFF, 0, o);
    n_cmp++;
    if (o.rdata !== 32'hFFFF_FF80 || o.be !== 4'b1000) begin
      n_fail++; $display("FAIL lb_signed: got rdata %h be %b expected ffffff80 1000", o.rdata, o.be);
    end
    run_txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h203, $urandom, 32'h80FF_FFFF, 0, o);
    n_cmp++;
    if (o.rdata !== 32'h0000_0080 || o.be !== 4'b1000) begin
      n_fail++; $display("FAIL lb_unsigned: got rdata %h be %b expected 00000080 1000", o.rdata, o.be);
    end
    model_rdata = 32'h0000_0080;
  endtask

  task automatic test_half_store();
    obs_t o;
    run_txn(1'b0, 1'b1, 2'b10, 1'b0, 32'h12, 32'h0000_ABCD, $urandom, 3, o);
    n_cmp++;
    if (o.we !== 1'b1 || o.be !== 4'b1100 || o.wd !== 32'hABCD_ABCD || o.addr !== 32'h10) begin
      n_fail++;
      $display("FAIL sh_bus: got we %b be %b wdata %h addr %h expected 1 1100 abcdabcd 10",
               o.we, o.be, o.wd, o.addr);
    end
    n_cmp++;
    if (!o.stable || o.nreq !== 4) begin
      n_fail++; $display("FAIL sh_hold: got stable %b req_cycles %0d expected 1 4", o.stable, o.nreq);
    end
    n_cmp++;
    if (o.lat !== 5 || o.err !== 1'b0) begin
      n_fail++; $display("FAIL sh_latency: got %0d err %b expected 5 0", o.lat, o.err);
    end
    n_cmp++;
    if (o.rdata !== model_rdata) begin
      n_fail++; $display("FAIL sh_rdata_kept: got %h expected %h", o.rdata, model_rdata);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    bit          rds [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    bit          wrs [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  szs [4] = '{2'b11, 2'b00, 2'b01, 2'b10};
    logic [31:0] adrs[4] = '{32'h101, 32'h100, 32'h100, 32'h103};
    for (int i = 0; i < 4; i++) begin
      run_txn(rds[i], wrs[i], szs[i], 1'b0, adrs[i], $urandom, $urandom, 0, o);
      n_cmp++;
      if (o.req_seen || o.lat !== 1 || o.err !== 1'b1 || o.rdata !== model_rdata) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got req %b lat %0d err %b rdata %h expected 0 1 1 %h",
                 i, o.req_seen, o.lat, o.err, o.rdata, model_rdata);
      end
    end
  endtask

  task automatic test_ignored();
    bit bad;
    bad = 1'b0;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.mem_read = 1'b0; rq.mem_write = 1'b0;
    rq.mem_size = 2'b11; rq.addr = 32'h40;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rq.req_ready !== 1'b1 || dm.dmem_req !== 1'b0 || rq.done !== 1'b0) bad = 1'b1;
    end
    rq.req_valid = 1'b0;
    n_cmp++;
    if (bad) begin
      n_fail++; $display("FAIL no_op_request: got activity expected idle with ready=1");
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    bit saw_done;
    logic [31:0] mw;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.mem_read = 1'b1; rq.mem_write = 1'b0;
    rq.mem_size = 2'b11; rq.mem_sign = 1'b0; rq.addr = 32'h40;
    @(negedge clk);
    rq.req_valid = 1'b0;
    n_cmp++;
    if (dm.dmem_req !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_pre: got dmem_req %b expected 1", dm.dmem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (dm.dmem_req !== 1'b0 || rq.req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_async: got dmem_req %b ready %b expected 0 1", dm.dmem_req, rq.req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_rdata = 32'd0;
    saw_done = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rq.done !== 1'b0 || rq.req_ready !== 1'b1) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_fail++; $display("FAIL rst_mid_quiet: got done or busy after abort expected idle");
    end
    mw = $urandom;
    run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h108, $urandom, mw, 1, o);
    n_cmp++;
    if (o.lat !== 3 || o.rdata !== mw || o.err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_next: got lat %0d rdata %h err %b expected 3 %h 0", o.lat, o.rdata, o.err, mw);
    end
    model_rdata = mw;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] mw, ex;
    int done_cycles[$];
    @(negedge clk);
    rq.req_valid = 1'b1; rq.mem_read = 1'b1; rq.mem_write = 1'b0;
    rq.mem_size = 2'b10; rq.mem_sign = 1'b1; rq.addr = 32'h202;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (rq.done) begin
        done_cycles.push_back(c);
        ex = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
        n_cmp++;
        if (rq.rdata !== ex) begin
          n_fail++; $display("FAIL b2b_rdata@%0d: got %h expected %h", c, rq.rdata, ex);
        end
        model_rdata = ex;
      end
      dm.dmem_ack = dm.dmem_req;
      if (dm.dmem_req) begin
        mw = $urandom;
        dm.dmem_rdata = mw;
        exp_q.push_back(m_load(mw, 2'b10, 1'b1, 32'h202));
      end
    end
    rq.req_valid = 1'b0;
    dm.dmem_ack = 1'b0;
    n_cmp++;
    if (done_cycles.size() !== 4 || done_cycles[0] !== 2 || done_cycles[3] !== 11) begin
      n_fail++;
      $display("FAIL b2b_rate: got %0d done pulses first %0d expected 4 pulses at 2,5,8,11",
               done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    obs_t o;
    bit rd, wr, sg, legal;
    logic [1:0] sz;
    logic [31:0] a, wd, mw, exp_rd;
    int waits, r, exp_lat;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      rd = (r == 0) || (r < 5);
      wr = (r == 0) || (r >= 5);
      sz = 2'($urandom);
      sg = 1'($urandom);
      a = $urandom & 32'h0000_FFFF;
      wd = $urandom; mw = $urandom;
      waits = $urandom_range(0, 3);
      legal = m_legal(rd, wr, sz, a);
      exp_lat = legal ? waits + 2 : 1;
      exp_rd = (legal && rd) ? m_load(mw, sz, sg, a) : model_rdata;
      run_txn(rd, wr, sz, sg, a, wd, mw, waits, o);
      n_cmp++;
      if (o.lat !== exp_lat || o.err !== !legal || !o.pulse_ok) begin
        n_fail++;
        $display("FAIL rnd[%0d] timing: got lat %0d err %b pulse_ok %b expected %0d %b 1",
                 i, o.lat, o.err, o.pulse_ok, exp_lat, !legal);
      end
      n_cmp++;
      if (o.rdata !== exp_rd) begin
        n_fail++; $display("FAIL rnd[%0d] rdata: got %h expected %h", i, o.rdata, exp_rd);
      end
      n_cmp++;
      if (o.req_seen !== legal ||
          (legal && (o.nreq !== waits + 1 || !o.stable || o.we !== wr ||
                     o.addr !== (a & ~32'd3) || o.be !== m_be(sz, a) ||
                     (wr && o.wd !== m_store(sz, wd))))) begin
        n_fail++;
        $display("FAIL rnd[%0d] bus: got req %b cyc %0d we %b addr %h be %b wd %h expected req %b cyc %0d addr %h be %b wd %h",
                 i, o.req_seen, o.nreq, o.we, o.addr, o.be, o.wd,
                 legal, waits + 1, a & ~32'd3, m_be(sz, a), m_store(sz, wd));
      end
      model_rdata = exp_rd;
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    obs_t o;
    run_txn(1'b1, 1'b0, 2'b11, 1'b0, 32'h300, $urandom, $urandom, -1, o);
    n_cmp++;
    if (o.nreq !== TMO || o.lat !== TMO + 1 || o.err !== 1'b1 || o.rdata !== model_rdata) begin
      n_fail++;
      $display("FAIL timeout: got req_cycles %0d lat %0d err %b rdata %h expected %0d %0d 1 %h",
               o.nreq, o.lat, o.err, o.rdata, TMO, TMO + 1, model_rdata);
    end
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rq.req_valid = 1'b0; rq.mem_read = 1'b0; rq.mem_write = 1'b0;
    rq.mem_size = 2'b00; rq.mem_sign = 1'b0; rq.addr = '0; rq.wdata = '0;
    dm.dmem_ack = 1'b0; dm.dmem_rdata = '0;
    model_rdata = 32'd0;
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_word_load();
    test_byte_loads();
    test_half_store();
    test_illegal();
    test_ignored();
    test_reset_mid_access();
    test_back_to_back();
    test_random();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the main control decoder, in the MEM stage. Consumes the decoder's MemRead, MemWrite, MemDataSize and MemDataSign outputs, plus the ALU-computed address and the store data.
- Runs a handshaked data-memory transaction on a word-wide bus. Handles byte-lane steering, sign/zero extension and misalignment detection.
- Returns a registered load result and a done pulse to the writeback path.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT, 255, ack-wait cycle limit; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM-stage request present
- req_ready  out  1  unit can accept a request
- mem_read  in  1  load (decoder MemRead)
- mem_write  in  1  store (decoder MemWrite)
- mem_size  in  2  11 = word, 10 = half, 01 = byte, 00 = illegal (decoder MemDataSize)
- mem_sign  in  1  1 = sign-extend loads (decoder MemDataSign)
- addr  in  ADDR_W  byte address
- wdata  in  32  store data, right-justified
- rdata  out  32  extended load result
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done: misaligned, illegal, or timeout
- busy  out  1  unit not idle; pipeline stall
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  ADDR_W  word-aligned address, addr[1:0] forced to 00
- dmem_be  out  4  byte enables; bit0 = byte at addr offset 0 (little-endian)
- dmem_wdata  out  32  lane-steered store data
- dmem_ack  in  1  bus completion, single cycle
- dmem_rdata  in  32  read word, valid with dmem_ack

Behaviour:
- Reset is asynchronous and active-low. rst_n low forces state IDLE and clears every registered output: rdata = 0, done = 0, err = 0, dmem_req = 0, dmem_we = 0, dmem_be = 0, dmem_addr = 0, dmem_wdata = 0.
- req_ready = (state == IDLE). busy = !req_ready.
- A request is accepted on a clock edge where req_valid & req_ready & (mem_read | mem_write). If neither mem_read nor mem_write is set, the request is ignored and no done pulse is produced.
- At acceptance, all request fields are captured into registers. Inputs are don't-care after that edge.

State machine: IDLE, REQ, RESP.
- IDLE -> REQ on acceptance when the request is legal.
- IDLE -> RESP on acceptance when the request is illegal. Illegal means any of:
  - mem_size = 00
  - mem_read & mem_write both set
  - half access with addr[0] = 1
  - word access with addr[1:0] != 00
- Illegal requests produce no bus activity: dmem_req stays 0 and err = 1 with done.
- REQ: dmem_req = 1, and dmem_we/addr/be/wdata are held stable until an edge with dmem_ack = 1. REQ -> RESP on that edge.
- For loads, the ack edge registers rdata from dmem_rdata. For stores, rdata is unchanged.
- RESP: done = 1 for exactly one cycle, then RESP -> IDLE. dmem_req = 0 in RESP.

Latency and back-to-back:
- Legal access: done rises 2 cycles after acceptance when ack arrives in the first REQ cycle.
- Each additional wait cycle adds 1.
- Back-to-back requests: the earliest next acceptance is the cycle after RESP.

Byte enables (o = addr[1:0]):
- byte: be = 0001 << o
- half: be = 0011 << o
- word: be = 1111

Store data:
- byte: wdata[7:0] replicated to all four lanes.
- half: wdata[15:0] replicated to both halves.
- word: wdata passed through unchanged.

Load data:
- Extract the byte at lane o, or the half at lanes o..o+1.
- If mem_sign = 1, sign-extend to 32 bits; otherwise zero-extend.
- Word loads ignore mem_sign.

Other boundary conditions:
- dmem_ack while not in REQ is ignored.
- rst_n asserted in REQ aborts the access immediately: dmem_req drops asynchronously and no done pulse is produced.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- When defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ack.
  - When the counter reaches TIMEOUT, the unit drops dmem_req, goes to RESP, and asserts done with err = 1.
  - rdata is unchanged on timeout.
- When undefined: no counter is built, and REQ waits for dmem_ack indefinitely.

Test Plan:
- Word load: LW, addr = 0x104, dmem_rdata = 0xDEADBEEF, ack in the first REQ cycle -> dmem_addr = 0x104, be = 1111, done 2 cycles after acceptance, rdata = 0xDEADBEEF, err = 0.
- Signed and unsigned byte loads: addr = 0x203, dmem_rdata = 0x80FFFFFF -> signed byte load gives rdata = 0xFFFFFF80; unsigned byte load gives rdata = 0x00000080; be = 1000 in both cases.
- Half store: addr = 0x12, wdata = 0x0000ABCD, ack after 3 wait cycles -> dmem_we = 1, be = 1100, dmem_wdata = 0xABCDABCD, fields stable throughout REQ, done 5 cycles after acceptance.
- Misaligned word store: addr = 0x101 -> dmem_req never asserts, done 1 cycle after acceptance with err = 1; mem_size = 00 gives the same result.
- Reset mid-access: rst_n pulsed low in REQ -> dmem_req = 0 immediately, no done pulse, req_ready = 1 after release; the next LW completes normally.
- Timeout (MEM_TIMEOUT_EN defined, TIMEOUT = 4): ack never arrives -> dmem_req drops after 4 REQ cycles, done = 1, err = 1.
